sd_regbank_bus: RTL and testbench



---
 rtl/sd_regbank_bus_if.sv | 17 +
 rtl/sd_regbank_bus.sv | 215 +++++++++++++++++++++
 tb/tb_sd_regbank_bus.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_regbank_bus_if.sv
// Host-side register bus for the SD controller register bank:
// a req/ack handshake with byte enables and registered read data.
interface sd_regbank_bus_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
) ();
  logic                  req;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W/8-1:0]   be;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W-1:0]     rdata;
  logic                  ack;

  modport master (output req, we, addr, be, wdata, input rdata, ack);
  modport slave  (input req, we, addr, be, wdata, output rdata, ack);
endinterface

// File: rtl/sd_regbank_bus.sv
// SD controller register bank: byte-lane bus access, sticky W1C interrupt
// status, command-start / interrupt-clear pulses and a registered irq.
module sd_regbank_bus #(
  parameter int          DATA_W        = 8,
  parameter int          ADDR_W        = 7,
  parameter logic [11:0] BLKSIZE_RESET = 12'd511,
  parameter logic [31:0] VOLTAGE       = 32'd3300,
  parameter logic [15:0] CAPA          = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  sd_regbank_bus_if.slave bus,
  input  logic [31:0] resp0,
  input  logic [31:0] resp1,
  input  logic [31:0] resp2,
  input  logic [31:0] resp3,
  input  logic [4:0]  cmd_int_set,
  input  logic [2:0]  data_int_set,
  output logic [31:0] argument,
  output logic [31:0] dma_addr,
  output logic [13:0] command,
  output logic [23:0] cmd_timeout,
  output logic [23:0] data_timeout,
  output logic [11:0] blksize,
  output logic [15:0] blkcnt,
  output logic [7:0]  clock_divider,
  output logic        controller,
  output logic        software_reset,
  output logic [4:0]  cmd_int_en,
  output logic [2:0]  data_int_en,
  output logic [4:0]  cmd_int_status,
  output logic [2:0]  data_int_status,
  output logic        cmd_start,
  output logic        cmd_int_rst,
  output logic        data_int_rst,
  output logic        irq
);
  localparam int LANES = DATA_W / 8;
  // Clears the address bits that select a lane inside one bus beat.
  localparam logic [1:0] BASE_MASK = 2'(~(LANES - 1));

  localparam int W_ARG = 0,  W_CMD = 1,  W_R0 = 2,  W_R1 = 3,  W_R2 = 4,  W_R3 = 5;
  localparam int W_CTRL = 6, W_BLKS = 7, W_VOLT = 8, W_SRST = 9, W_CTO = 10;
  localparam int W_DTO = 11, W_CISR = 12, W_CISER = 13, W_CLKD = 14, W_CAPA = 15;
  localparam int W_DISR = 16, W_BCNT = 17, W_DISER = 18, W_DMA = 19;

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;
  state_t state_q, state_d;

  logic        accept, wr;
  int          widx;
  logic [1:0]  base;
  logic [3:0]  wmask;
  logic [31:0] wword, bm, rword;

  logic [31:0] argument_q, argument_d, dma_addr_q, dma_addr_d;
  logic [13:0] command_q, command_d;
  logic [23:0] cmd_timeout_q, cmd_timeout_d, data_timeout_q, data_timeout_d;
  logic [11:0] blksize_q, blksize_d;
  logic [15:0] blkcnt_q, blkcnt_d;
  logic [7:0]  clock_divider_q, clock_divider_d;
  logic        controller_q, controller_d, software_reset_q, software_reset_d;
  logic [4:0]  cmd_int_en_q, cmd_int_en_d, cmd_int_status_q, cmd_int_status_d;
  logic [2:0]  data_int_en_q, data_int_en_d, data_int_status_q, data_int_status_d;
  logic        cmd_start_q, cmd_start_d, cmd_int_rst_q, cmd_int_rst_d;
  logic        data_int_rst_q, data_int_rst_d, irq_q, irq_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [31:0] m);
    return (old & ~m) | (wd & m);
  endfunction

  // Holding req through ack parks in S_WAIT so one request is one access.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: if (bus.req) begin
        accept  = 1'b1;
        state_d = S_ACK;
      end
      S_ACK:  state_d = bus.req ? S_WAIT : S_IDLE;
      S_WAIT: if (!bus.req) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    widx  = int'(bus.addr[ADDR_W-1:2]);
    base  = bus.addr[1:0] & BASE_MASK;
    wword = 32'(bus.wdata) << {base, 3'b000};
    wmask = 4'(bus.be) << base;
    bm    = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};
    wr    = accept & bus.we;

    case (widx)
      W_ARG:   rword = argument_q;
      W_CMD:   rword = {18'b0, command_q};
      W_R0:    rword = resp0;
      W_R1:    rword = resp1;
      W_R2:    rword = resp2;
      W_R3:    rword = resp3;
      W_CTRL:  rword = {31'b0, controller_q};
      W_BLKS:  rword = {20'b0, blksize_q};
      W_VOLT:  rword = VOLTAGE;
      W_SRST:  rword = {31'b0, software_reset_q};
      W_CTO:   rword = {8'b0, cmd_timeout_q};
      W_DTO:   rword = {8'b0, data_timeout_q};
      W_CISR:  rword = {27'b0, cmd_int_status_q};
      W_CISER: rword = {27'b0, cmd_int_en_q};
      W_CLKD:  rword = {24'b0, clock_divider_q};
      W_CAPA:  rword = {16'b0, CAPA};
      W_DISR:  rword = {29'b0, data_int_status_q};
      W_BCNT:  rword = {16'b0, blkcnt_q};
      W_DISER: rword = {29'b0, data_int_en_q};
      W_DMA:   rword = dma_addr_q;
      default: rword = 32'b0;
    endcase
    rdata_d = (accept && !bus.we) ? DATA_W'(rword >> {base, 3'b000}) : '0;

    argument_d       = (wr && widx == W_ARG)   ? merge(argument_q, wword, bm) : argument_q;
    command_d        = (wr && widx == W_CMD)   ? 14'(merge({18'b0, command_q}, wword, bm)) : command_q;
    controller_d     = (wr && widx == W_CTRL)  ? 1'(merge({31'b0, controller_q}, wword, bm)) : controller_q;
    blksize_d        = (wr && widx == W_BLKS)  ? 12'(merge({20'b0, blksize_q}, wword, bm)) : blksize_q;
    software_reset_d = (wr && widx == W_SRST)  ? 1'(merge({31'b0, software_reset_q}, wword, bm)) : software_reset_q;
    cmd_timeout_d    = (wr && widx == W_CTO)   ? 24'(merge({8'b0, cmd_timeout_q}, wword, bm)) : cmd_timeout_q;
    data_timeout_d   = (wr && widx == W_DTO)   ? 24'(merge({8'b0, data_timeout_q}, wword, bm)) : data_timeout_q;
    cmd_int_en_d     = (wr && widx == W_CISER) ? 5'(merge({27'b0, cmd_int_en_q}, wword, bm)) : cmd_int_en_q;
    clock_divider_d  = (wr && widx == W_CLKD)  ? 8'(merge({24'b0, clock_divider_q}, wword, bm)) : clock_divider_q;
    blkcnt_d         = (wr && widx == W_BCNT)  ? 16'(merge({16'b0, blkcnt_q}, wword, bm)) : blkcnt_q;
    data_int_en_d    = (wr && widx == W_DISER) ? 3'(merge({29'b0, data_int_en_q}, wword, bm)) : data_int_en_q;
    dma_addr_d       = (wr && widx == W_DMA)   ? merge(dma_addr_q, wword, bm) : dma_addr_q;

    // Set is OR-ed in after the clear so a same-cycle event is never lost.
    cmd_int_status_d  = cmd_int_status_q;
    data_int_status_d = data_int_status_q;
    if (wr && widx == W_CISR) cmd_int_status_d  = cmd_int_status_q  & ~(wword[4:0] & bm[4:0]);
    if (wr && widx == W_DISR) data_int_status_d = data_int_status_q & ~(wword[2:0] & bm[2:0]);
    cmd_int_status_d  = cmd_int_status_d  | cmd_int_set;
    data_int_status_d = data_int_status_d | data_int_set;

    cmd_start_d    = wr && widx == W_ARG && wmask[3];
    cmd_int_rst_d  = wr && widx == W_CISR;
    data_int_rst_d = wr && widx == W_DISR;
    irq_d = (|(cmd_int_status_q & cmd_int_en_q)) | (|(data_int_status_q & data_int_en_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= S_IDLE;
      rdata_q           <= '0;
      argument_q        <= '0;
      command_q         <= '0;
      controller_q      <= 1'b0;
      blksize_q         <= BLKSIZE_RESET;
      software_reset_q  <= 1'b0;
      cmd_timeout_q     <= '0;
      data_timeout_q    <= '0;
      cmd_int_en_q      <= '0;
      clock_divider_q   <= '0;
      blkcnt_q          <= '0;
      data_int_en_q     <= '0;
      dma_addr_q        <= '0;
      cmd_int_status_q  <= '0;
      data_int_status_q <= '0;
      cmd_start_q       <= 1'b0;
      cmd_int_rst_q     <= 1'b0;
      data_int_rst_q    <= 1'b0;
      irq_q             <= 1'b0;
    end else begin
      state_q           <= state_d;
      rdata_q           <= rdata_d;
      argument_q        <= argument_d;
      command_q         <= command_d;
      controller_q      <= controller_d;
      blksize_q         <= blksize_d;
      software_reset_q  <= software_reset_d;
      cmd_timeout_q     <= cmd_timeout_d;
      data_timeout_q    <= data_timeout_d;
      cmd_int_en_q      <= cmd_int_en_d;
      clock_divider_q   <= clock_divider_d;
      blkcnt_q          <= blkcnt_d;
      data_int_en_q     <= data_int_en_d;
      dma_addr_q        <= dma_addr_d;
      cmd_int_status_q  <= cmd_int_status_d;
      data_int_status_q <= data_int_status_d;
      cmd_start_q       <= cmd_start_d;
      cmd_int_rst_q     <= cmd_int_rst_d;
      data_int_rst_q    <= data_int_rst_d;
      irq_q             <= irq_d;
    end
  end

  assign bus.ack         = (state_q == S_ACK);
  assign bus.rdata       = rdata_q;
  assign argument        = argument_q;
  assign dma_addr        = dma_addr_q;
  assign command         = command_q;
  assign cmd_timeout     = cmd_timeout_q;
  assign data_timeout    = data_timeout_q;
  assign blksize         = blksize_q;
  assign blkcnt          = blkcnt_q;
  assign clock_divider   = clock_divider_q;
  assign controller      = controller_q;
  assign software_reset  = software_reset_q;
  assign cmd_int_en      = cmd_int_en_q;
  assign data_int_en     = data_int_en_q;
  assign cmd_int_status  = cmd_int_status_q;
  assign data_int_status = data_int_status_q;
  assign cmd_start       = cmd_start_q;
  assign cmd_int_rst     = cmd_int_rst_q;
  assign data_int_rst    = data_int_rst_q;
  assign irq             = irq_q;
endmodule

// File: tb/tb_sd_regbank_bus.sv
// Bench for sd_regbank_bus: a 32-bit instance checked against a word-level
// register-map model, plus an 8-bit instance for byte-wide argument writes.
module tb_sd_regbank_bus;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] r0, r1, r2, r3;
  logic [4:0]  cset;
  logic [2:0]  dset;

  sd_regbank_bus_if #(.DATA_W(32), .ADDR_W(7)) if32 ();
  sd_regbank_bus_if #(.DATA_W(8),  .ADDR_W(7)) if8 ();

  logic [31:0] argument, dma_addr;
  logic [13:0] command;
  logic [23:0] cmd_timeout, data_timeout;
  logic [11:0] blksize;
  logic [15:0] blkcnt;
  logic [7:0]  clock_divider;
  logic        controller, software_reset;
  logic [4:0]  cmd_int_en, cmd_int_status;
  logic [2:0]  data_int_en, data_int_status;
  logic        cmd_start, cmd_int_rst, data_int_rst, irq;

  logic [31:0] b_argument, b_dma_addr;
  logic [13:0] b_command;
  logic [23:0] b_cmd_timeout, b_data_timeout;
  logic [11:0] b_blksize;
  logic [15:0] b_blkcnt;
  logic [7:0]  b_clock_divider;
  logic        b_controller, b_software_reset;
  logic [4:0]  b_cmd_int_en, b_cmd_int_status;
  logic [2:0]  b_data_int_en, b_data_int_status;
  logic        b_cmd_start, b_cmd_int_rst, b_data_int_rst, b_irq;

  sd_regbank_bus #(.DATA_W(32), .ADDR_W(7)) u32 (
    .clk(clk), .rst(rst), .bus(if32),
    .resp0(r0), .resp1(r1), .resp2(r2), .resp3(r3),
    .cmd_int_set(cset), .data_int_set(dset),
    .argument(argument), .dma_addr(dma_addr), .command(command),
    .cmd_timeout(cmd_timeout), .data_timeout(data_timeout), .blksize(blksize),
    .blkcnt(blkcnt), .clock_divider(clock_divider), .controller(controller),
    .software_reset(software_reset), .cmd_int_en(cmd_int_en), .data_int_en(data_int_en),
    .cmd_int_status(cmd_int_status), .data_int_status(data_int_status),
    .cmd_start(cmd_start), .cmd_int_rst(cmd_int_rst), .data_int_rst(data_int_rst), .irq(irq)
  );

  sd_regbank_bus #(.DATA_W(8), .ADDR_W(7)) u8 (
    .clk(clk), .rst(rst), .bus(if8),
    .resp0(r0), .resp1(r1), .resp2(r2), .resp3(r3),
    .cmd_int_set(5'd0), .data_int_set(3'd0),
    .argument(b_argument), .dma_addr(b_dma_addr), .command(b_command),
    .cmd_timeout(b_cmd_timeout), .data_timeout(b_data_timeout), .blksize(b_blksize),
    .blkcnt(b_blkcnt), .clock_divider(b_clock_divider), .controller(b_controller),
    .software_reset(b_software_reset), .cmd_int_en(b_cmd_int_en), .data_int_en(b_data_int_en),
    .cmd_int_status(b_cmd_int_status), .data_int_status(b_data_int_status),
    .cmd_start(b_cmd_start), .cmd_int_rst(b_cmd_int_rst), .data_int_rst(b_data_int_rst), .irq(b_irq)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: one 32-bit word per register offset, plus the two W1C words.
  logic [31:0] m_reg [0:31];
  logic [4:0]  m_cisr;
  logic [2:0]  m_disr;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    m_reg[7] = 32'd511;
    m_cisr = 5'd0;
    m_disr = 3'd0;
  endtask

  function automatic logic [31:0] reg_mask(input int w);
    case (w)
      0, 19:  return 32'hFFFF_FFFF;
      1:      return 32'h0000_3FFF;
      6, 9:   return 32'h0000_0001;
      7:      return 32'h0000_0FFF;
      10, 11: return 32'h00FF_FFFF;
      13:     return 32'h0000_001F;
      14:     return 32'h0000_00FF;
      17:     return 32'h0000_FFFF;
      18:     return 32'h0000_0007;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input int w);
    case (w)
      2: return r0;
      3: return r1;
      4: return r2;
      5: return r3;
      8: return 32'd3300;
      12: return {27'b0, m_cisr};
      15: return 32'h0;
      16: return {29'b0, m_disr};
      default: return m_reg[w];
    endcase
  endfunction

  function automatic logic m_irq();
    return (|(m_cisr & m_reg[13][4:0])) | (|(m_disr & m_reg[18][2:0]));
  endfunction

  task automatic check_outs();
    chk("argument", argument, m_reg[0]);
    chk("command", 32'(command), m_reg[1]);
    chk("controller", 32'(controller), m_reg[6]);
    chk("blksize", 32'(blksize), m_reg[7]);
    chk("software_reset", 32'(software_reset), m_reg[9]);
    chk("cmd_timeout", 32'(cmd_timeout), m_reg[10]);
    chk("data_timeout", 32'(data_timeout), m_reg[11]);
    chk("cmd_int_status", 32'(cmd_int_status), 32'(m_cisr));
    chk("cmd_int_en", 32'(cmd_int_en), m_reg[13]);
    chk("clock_divider", 32'(clock_divider), m_reg[14]);
    chk("data_int_status", 32'(data_int_status), 32'(m_disr));
    chk("blkcnt", 32'(blkcnt), m_reg[17]);
    chk("data_int_en", 32'(data_int_en), m_reg[18]);
    chk("dma_addr", dma_addr, m_reg[19]);
  endtask

  // One access on the 32-bit instance with optional event pulses in the accept cycle.
  task automatic do32(input logic wr, input logic [6:0] a, input logic [3:0] be,
                      input logic [31:0] wd, input logic [4:0] sc, input logic [2:0] sd);
    int w;
    logic [31:0] bm, msk, exp_rd;
    w   = int'(a[6:2]);
    bm  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    msk = reg_mask(w);
    exp_rd = wr ? 32'd0 : m_read(w);
    if32.req = 1'b1; if32.we = wr; if32.addr = a; if32.be = be; if32.wdata = wd;
    cset = sc; dset = sd;
    @(posedge clk); #1;
    cset = 5'd0; dset = 3'd0; if32.req = 1'b0;
    chk("ack_n1", 32'(if32.ack), 32'd1);
    if (!wr) chk("rdata", if32.rdata, exp_rd);
    chk("cmd_start_n1", 32'(cmd_start), 32'(wr && w == 0 && be[3]));
    chk("cmd_int_rst_n1", 32'(cmd_int_rst), 32'(wr && w == 12));
    chk("data_int_rst_n1", 32'(data_int_rst), 32'(wr && w == 16));
    if (wr) begin
      if (w == 12)      m_cisr = m_cisr & ~(wd[4:0] & bm[4:0]);
      else if (w == 16) m_disr = m_disr & ~(wd[2:0] & bm[2:0]);
      else              m_reg[w] = (m_reg[w] & ~(bm & msk)) | (wd & bm & msk);
    end
    m_cisr = m_cisr | sc;
    m_disr = m_disr | sd;
    @(posedge clk); #1;
    chk("ack_n2", 32'(if32.ack), 32'd0);
    chk("cmd_start_n2", 32'(cmd_start), 32'd0);
    chk("irq", 32'(irq), 32'(m_irq()));
    check_outs();
  endtask

  task automatic do8(input logic wr, input logic [6:0] a, input logic [7:0] wd,
                     input logic [7:0] exp_rd);
    if8.req = 1'b1; if8.we = wr; if8.addr = a; if8.be = 1'b1; if8.wdata = wd;
    @(posedge clk); #1;
    if8.req = 1'b0;
    chk("ack8_n1", 32'(if8.ack), 32'd1);
    chk("cmd_start8", 32'(b_cmd_start), 32'(wr && a == 7'h03));
    if (!wr) chk("rdata8", 32'(if8.rdata), 32'(exp_rd));
    @(posedge clk); #1;
    chk("ack8_n2", 32'(if8.ack), 32'd0);
  endtask

  initial begin
    int acks, starts;
    rst = 1'b1;
    r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
    cset = 5'd0; dset = 3'd0;
    if32.req = 1'b0; if32.we = 1'b0; if32.addr = '0; if32.be = '0; if32.wdata = '0;
    if8.req = 1'b0;  if8.we = 1'b0;  if8.addr = '0;  if8.be = '0;  if8.wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(if32.ack), 32'd0);
    chk("rst_rdata", if32.rdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_pulses", 32'({cmd_start, cmd_int_rst, data_int_rst}), 32'd0);
    check_outs();
    chk("rst_u8_blksize", 32'(b_blksize), 32'd511);
    chk("rst_u8_zero", 32'(|{b_argument, b_dma_addr, b_command, b_cmd_timeout, b_data_timeout,
        b_blkcnt, b_clock_divider, b_controller, b_software_reset, b_cmd_int_en, b_data_int_en,
        b_cmd_int_status, b_data_int_status, b_cmd_start, b_cmd_int_rst, b_data_int_rst, b_irq,
        if8.ack, if8.rdata}), 32'd0);
    rst = 1'b0;

    // Byte-wide bus: command starts only when argument byte 3 is written.
    do8(1'b1, 7'h00, 8'h12, 8'h00);
    do8(1'b1, 7'h01, 8'h34, 8'h00);
    do8(1'b1, 7'h02, 8'h56, 8'h00);
    do8(1'b1, 7'h03, 8'h78, 8'h00);
    chk("u8_argument", b_argument, 32'h7856_3412);
    do8(1'b0, 7'h02, 8'h00, 8'h56);
    do8(1'b0, 7'h20, 8'h00, 8'hE4);
    do8(1'b0, 7'h21, 8'h00, 8'h0C);

    // Partial lanes and register-width truncation.
    do32(1'b1, 7'h1C, 4'b0011, 32'hFFFF_FFFF, 5'd0, 3'd0);
    chk("blksize_fff", 32'(blksize), 32'h0000_0FFF);
    do32(1'b1, 7'h04, 4'b1111, 32'hDEAD_BEEF, 5'd0, 3'd0);
    do32(1'b0, 7'h04, 4'b0000, 32'h0, 5'd0, 3'd0);
    chk("command_14b", 32'(command), 32'h0000_3EEF);

    // Interrupt set / W1C / set-wins, with a read racing a set pulse.
    do32(1'b1, 7'h34, 4'b1111, 32'h0000_0004, 5'd0, 3'd0);
    do32(1'b0, 7'h30, 4'b0000, 32'h0, 5'b00101, 3'd0);
    chk("irq_set", 32'(irq), 32'd1);
    do32(1'b1, 7'h30, 4'b1111, 32'h0000_0004, 5'd0, 3'd0);
    chk("cisr_after_w1c", 32'(cmd_int_status), 32'h0000_0001);
    chk("irq_clear", 32'(irq), 32'd0);
    do32(1'b1, 7'h30, 4'b1111, 32'h0000_0004, 5'b00100, 3'd0);
    chk("set_wins", 32'(cmd_int_status[2]), 32'd1);
    do32(1'b1, 7'h48, 4'b0001, 32'h0000_0007, 5'd0, 3'b010);
    do32(1'b1, 7'h40, 4'b0001, 32'h0000_0002, 5'd0, 3'd0);

    // Read-only and unmapped offsets.
    do32(1'b0, 7'h20, 4'b0000, 32'h0, 5'd0, 3'd0);
    do32(1'b0, 7'h3C, 4'b0000, 32'h0, 5'd0, 3'd0);
    do32(1'b0, 7'h50, 4'b0000, 32'h0, 5'd0, 3'd0);
    do32(1'b1, 7'h08, 4'b1111, 32'h1234_5678, 5'd0, 3'd0);
    do32(1'b0, 7'h08, 4'b0000, 32'h0, 5'd0, 3'd0);

    // req held for 5 cycles: exactly one access.
    acks = 0; starts = 0;
    if32.req = 1'b1; if32.we = 1'b1; if32.addr = 7'h00; if32.be = 4'hF; if32.wdata = 32'hA5A5_0001;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (c == 4) if32.req = 1'b0;
      acks += int'(if32.ack);
      starts += int'(cmd_start);
    end
    m_reg[0] = 32'hA5A5_0001;
    chk("hold_acks", 32'(acks), 32'd1);
    chk("hold_starts", 32'(starts), 32'd1);
    chk("hold_argument", argument, 32'hA5A5_0001);

    // Reset in the cycle after acceptance drops the ack and the start pulse.
    if32.req = 1'b1; if32.we = 1'b1; if32.addr = 7'h00; if32.be = 4'hF; if32.wdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    if32.req = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("midrst_ack", 32'(if32.ack), 32'd0);
    chk("midrst_start", 32'(cmd_start), 32'd0);
    chk("midrst_blksize", 32'(blksize), 32'd511);
    chk("midrst_irq", 32'(irq), 32'd0);
    check_outs();
    // Reset coincident with a request: no access at all.
    if32.req = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    if32.req = 1'b0; rst = 1'b0;
    chk("rstreq_ack", 32'(if32.ack), 32'd0);
    chk("rstreq_start", 32'(cmd_start), 32'd0);
    chk("rstreq_argument", argument, 32'd0);
    @(posedge clk); #1;
    chk("rstreq_ack2", 32'(if32.ack), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 150; i++) begin
      int w;
      logic wr;
      w  = int'($urandom_range(0, 21));
      wr = 1'($urandom_range(0, 1));
      do32(wr, 7'(w * 4 + int'($urandom_range(0, 3))), 4'($urandom), $urandom,
           ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0,
           ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
